// File: rtl/axil_ram_slave.sv
// AXI4-Lite slave backed by a NUM_WORDS x 32-bit word array, independent read/write FSMs.
// Define AXIL_RAM_SLAVE_DECERR_EN to answer out-of-window accesses with DECERR instead of aliasing.
//
// Flattened channel layout (MSB first):
//   axil_mosi = {awid[7:0], awaddr[31:0], awprot[2:0], awvalid, wdata[31:0], wstrb[3:0], wvalid,
//                bready, arid[7:0], araddr[31:0], arprot[2:0], arvalid, rready}            (127 b)
//   axil_miso = {awready, wready, bid[7:0], bresp[1:0], bvalid, arready, rid[7:0], rdata[31:0],
//                rresp[1:0], rvalid}                                                      (57 b)
//
// state    | meaning
// W_ACCEPT | collecting AW and W (either order or together); commit when both are present
// W_RESP   | write committed, bvalid held until bready
// R_ACCEPT | arready high, waiting for an AR handshake
// R_DATA   | read data sampled, rvalid held until rready
module axil_ram_slave #(
    parameter int          NUM_WORDS = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] RESET_VAL = '0
) (
    input  logic         aclk,
    input  logic         arst,
    input  logic [126:0] axil_mosi,
    output logic [56:0]  axil_miso
);

    localparam int          IDX_W      = $clog2(NUM_WORDS);
    localparam logic [31:0] WINDOW     = 32'(NUM_WORDS * 4);
    localparam logic [1:0]  AXI_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_DECERR = 2'b11;

    localparam logic [0:0] W_ACCEPT = 1'b0;
    localparam logic [0:0] W_RESP   = 1'b1;
    localparam logic [0:0] R_ACCEPT = 1'b0;
    localparam logic [0:0] R_DATA   = 1'b1;

    logic [7:0]  awid;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        bready;
    logic [7:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;

    assign {awid, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
            arid, araddr, arprot, arvalid, rready} = axil_mosi;

    logic        awready;
    logic        wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;

    assign axil_miso = {awready, wready, bid, bresp, bvalid,
                        arready, rid, rdata, rresp, rvalid};

    logic [31:0] mem [NUM_WORDS];

    logic [31:0]      aw_off;
    logic [31:0]      ar_off;
    logic [IDX_W-1:0] aw_idx;
    logic [IDX_W-1:0] ar_idx;
    logic             aw_in_range;
    logic             ar_in_range;

    assign aw_off = awaddr - BASE_ADDR;
    assign ar_off = araddr - BASE_ADDR;
    assign aw_idx = aw_off[2 +: IDX_W];
    assign ar_idx = ar_off[2 +: IDX_W];

`ifdef AXIL_RAM_SLAVE_DECERR_EN
    assign aw_in_range = (aw_off < WINDOW);
    assign ar_in_range = (ar_off < WINDOW);
`else
    // Aliasing mode: only the index bits matter, every address is treated as in-window.
    assign aw_in_range = 1'b1;
    assign ar_in_range = 1'b1;
`endif

    logic unused_bits;
    assign unused_bits = ^{awprot, arprot, aw_off, ar_off};

    // ---------------- write channel ----------------
    logic [0:0]       w_state;
    logic             aw_held;
    logic             w_held;
    logic [IDX_W-1:0] aw_idx_q;
    logic             aw_in_q;
    logic [7:0]       awid_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;

    logic             aw_hs;
    logic             w_hs;
    logic             aw_have;
    logic             w_have;
    logic             commit;
    logic [IDX_W-1:0] cm_idx;
    logic             cm_in_range;
    logic [7:0]       cm_id;
    logic [31:0]      cm_data;
    logic [3:0]       cm_strb;
    logic             cm_write;

    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign aw_have = aw_held | aw_hs;
    assign w_have  = w_held | w_hs;
    assign commit  = (w_state == W_ACCEPT) & aw_have & w_have;

    // The half that arrives on the commit edge is used straight from the bus, the other from its capture.
    assign cm_idx      = aw_held ? aw_idx_q : aw_idx;
    assign cm_in_range = aw_held ? aw_in_q  : aw_in_range;
    assign cm_id       = aw_held ? awid_q   : awid;
    assign cm_data     = w_held  ? wdata_q  : wdata;
    assign cm_strb     = w_held  ? wstrb_q  : wstrb;
    assign cm_write    = commit & cm_in_range;

    always_ff @(posedge aclk) begin
        if (arst) begin
            w_state  <= W_ACCEPT;
            awready  <= 1'b0;
            wready   <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            aw_in_q  <= 1'b0;
            awid_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid   <= 1'b0;
            bid      <= '0;
            bresp    <= AXI_OKAY;
        end else begin
            case (w_state)
                W_ACCEPT: begin
                    if (aw_hs) begin
                        aw_held  <= 1'b1;
                        aw_idx_q <= aw_idx;
                        aw_in_q  <= aw_in_range;
                        awid_q   <= awid;
                    end
                    if (w_hs) begin
                        w_held  <= 1'b1;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                    end
                    if (commit) begin
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bid     <= cm_id;
                        bresp   <= cm_in_range ? AXI_OKAY : AXI_DECERR;
                        w_state <= W_RESP;
                    end else begin
                        awready <= ~aw_have;
                        wready  <= ~w_have;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_ACCEPT;
                    end
                end
                default: w_state <= W_ACCEPT;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (cm_write) begin
            for (int b = 0; b < 4; b++) begin
                if (cm_strb[b]) begin
                    mem[cm_idx][8*b +: 8] <= cm_data[8*b +: 8];
                end
            end
        end
    end

    // ---------------- read channel ----------------
    logic [0:0] r_state;

    // mem is sampled before any same-edge commit lands, so a colliding read sees the old word.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_state <= R_ACCEPT;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= AXI_OKAY;
        end else begin
            case (r_state)
                R_ACCEPT: begin
                    if (arvalid & arready) begin
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rid     <= arid;
                        rdata   <= ar_in_range ? mem[ar_idx] : '0;
                        rresp   <= ar_in_range ? AXI_OKAY : AXI_DECERR;
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_ACCEPT;
                    end
                end
                default: r_state <= R_ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_ram_slave.sv
// Directed bench for axil_ram_slave: response scoreboard fed by a word-array model, plus literal checks.
module tb_axil_ram_slave;

    localparam logic [31:0] BASE       = 32'h0000_0000;
    localparam int          WORDS      = 16;
    localparam logic [31:0] RESET_WORD = 32'h0000_0000;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    logic [7:0]  awid, arid;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;

    logic [126:0] axil_mosi;
    logic [56:0]  axil_miso;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [7:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    assign axil_mosi = {awid, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
                        arid, araddr, arprot, arvalid, rready};
    assign {awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid} = axil_miso;

    axil_ram_slave #(
        .NUM_WORDS(WORDS),
        .BASE_ADDR(BASE),
        .RESET_VAL(RESET_WORD)
    ) dut (
        .aclk(clk),
        .arst(arst),
        .axil_mosi(axil_mosi),
        .axil_miso(axil_miso)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic [7:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic [31:0] model_mem [WORDS];
    b_exp_t exp_b [$];
    r_exp_t exp_r [$];

    function automatic logic in_window(input logic [31:0] a);
        return (a - BASE) < 32'(WORDS * 4);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(((a - BASE) / 4) % WORDS);
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
`ifdef AXIL_RAM_SLAVE_DECERR_EN
        return in_window(a) ? 2'b00 : 2'b11;
`else
        return 2'b00;
`endif
    endfunction

    task automatic push_write(input logic [31:0] a, input logic [7:0] id,
                              input logic [31:0] d, input logic [3:0] s);
        b_exp_t e;
        e.id   = id;
        e.resp = model_resp(a);
        exp_b.push_back(e);
`ifdef AXIL_RAM_SLAVE_DECERR_EN
        if (!in_window(a)) return;
`endif
        for (int b = 0; b < 4; b++)
            if (s[b]) model_mem[word_of(a)][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic push_read(input logic [31:0] a, input logic [7:0] id);
        r_exp_t e;
        e.id   = id;
        e.resp = model_resp(a);
        e.data = model_mem[word_of(a)];
`ifdef AXIL_RAM_SLAVE_DECERR_EN
        if (!in_window(a)) e.data = 32'h0;
`endif
        exp_r.push_back(e);
    endtask

    // ---------------- compare process ----------------
    logic hold_b = 1'b0;
    logic hold_r = 1'b0;

    always @(negedge clk) begin
        if (arst) begin
            hold_b <= 1'b0;
            hold_r <= 1'b0;
        end else begin
            if (hold_b) check("b_valid_stable", 64'(bvalid), 64'd1);
            if (bvalid) begin
                check("b_expected", 64'(exp_b.size() != 0), 64'd1);
                if (exp_b.size() != 0) begin
                    check("b_id", 64'(bid), 64'(exp_b[0].id));
                    check("b_resp", 64'(bresp), 64'(exp_b[0].resp));
                    if (bready) void'(exp_b.pop_front());
                end
            end
            if (hold_r) check("r_valid_stable", 64'(rvalid), 64'd1);
            if (rvalid) begin
                check("r_expected", 64'(exp_r.size() != 0), 64'd1);
                if (exp_r.size() != 0) begin
                    check("r_id", 64'(rid), 64'(exp_r[0].id));
                    check("r_data", 64'(rdata), 64'(exp_r[0].data));
                    check("r_resp", 64'(rresp), 64'(exp_r[0].resp));
                    if (rready) void'(exp_r.pop_front());
                end
            end
            hold_b <= bvalid & ~bready;
            hold_r <= rvalid & ~rready;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] id, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
        logic aw_go, w_go, got;
        push_write(a, id, d, s);
        awaddr = a; awid = id; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
            @(negedge clk);
            aw_go = awvalid & awready;
            w_go  = wvalid & wready;
            tick();
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
        end
        check("aw_w_accepted", 64'({awvalid, wvalid}), 64'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        got = 1'b0; resp = 2'b00;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bvalid && bready) begin
                got  = 1'b1;
                resp = bresp;
            end
            tick();
        end
        check("b_returned", 64'(got), 64'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] id, output logic [31:0] d);
        logic go, got;
        push_read(a, id);
        araddr = a; arid = id; arvalid = 1'b1;
        for (int i = 0; i < 20 && arvalid; i++) begin
            @(negedge clk);
            go = arready;
            tick();
            if (go) arvalid = 1'b0;
        end
        check("ar_accepted", 64'(arvalid), 64'd0);
        arvalid = 1'b0;
        got = 1'b0; d = 32'h0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rvalid && rready) begin
                got = 1'b1;
                d   = rdata;
            end
            tick();
        end
        check("r_returned", 64'(got), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d;
        logic [1:0]  resp;

        arst = 1'b1;
        awid = '0; awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; arid = '0;
        awprot = 3'b101; arprot = 3'b010;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        for (int i = 0; i < WORDS; i++) model_mem[i] = RESET_WORD;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(axil_miso), 64'd0);
        arst = 1'b0;
        tick();
        check("ready_after_reset", 64'({awready, wready, arready}), 64'h7);

        // AW and W together, then readback
        push_write(32'h8, 8'h3C, 32'hDEADBEEF, 4'hF);
        awaddr = 32'h8; awid = 8'h3C; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t1_b", 64'({bvalid, bid, bresp, awready, wready}), 64'({1'b1, 8'h3C, 2'b00, 2'b00}));
        tick();
        check("t1_b_done", 64'({bvalid, awready, wready}), 64'b011);
        push_read(32'h8, 8'h11);
        araddr = 32'h8; arid = 8'h11; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("t1_r", 64'({rvalid, rid, rdata, arready}), 64'({1'b1, 8'h11, 32'hDEADBEEF, 1'b0}));
        tick();
        check("t1_r_done", 64'({rvalid, arready}), 64'b01);

        // W first, AW three cycles later
        push_write(32'h8, 8'h05, 32'h11223344, 4'b0101);
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("t2_after_w", 64'({awready, wready, bvalid}), 64'b100);
        tick();
        tick();
        check("t2_waiting_aw", 64'({awready, wready, bvalid}), 64'b100);
        awaddr = 32'h8; awid = 8'h05; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("t2_b", 64'({bvalid, bid, bresp}), 64'({1'b1, 8'h05, 2'b00}));
        tick();
        check("t2_b_done", 64'({bvalid, awready, wready}), 64'b011);
        do_read(32'h8, 8'h12, d);
        check("t2_readback", 64'(d), 64'h0DE22BE44);

        // B backpressure
        push_write(32'hC, 8'h21, 32'h12345678, 4'hF);
        bready = 1'b0;
        awaddr = 32'hC; awid = 8'h21; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_b_hold", 64'({bvalid, bid, awready, wready}), 64'({1'b1, 8'h21, 2'b00}));
            tick();
        end
        bready = 1'b1;
        tick();
        check("t3_b_release", 64'({bvalid, awready, wready}), 64'b011);

        // R backpressure
        push_read(32'hC, 8'h42);
        rready = 1'b0;
        araddr = 32'hC; arid = 8'h42; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_r_hold", 64'({rvalid, rid, rdata, arready}), 64'({1'b1, 8'h42, 32'h12345678, 1'b0}));
            tick();
        end
        rready = 1'b1;
        tick();
        check("t3_r_release", 64'({rvalid, arready}), 64'b01);

        // read handshake on the same edge as a write commit to the same word
        push_read(32'h4, 8'h66);
        push_write(32'h4, 8'h67, 32'hA5A5A5A5, 4'hF);
        awaddr = 32'h4; awid = 8'h67; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        araddr = 32'h4; arid = 8'h66;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("t4_collision_old", 64'({rvalid, rdata, bvalid}), 64'({1'b1, 32'h0, 1'b1}));
        tick();
        do_read(32'h4, 8'h68, d);
        check("t4_collision_new", 64'(d), 64'hA5A5A5A5);

        // out-of-window accesses
        do_write(32'h40, 8'h07, 32'hCAFEF00D, 4'hF, resp);
        do_read(32'h0, 8'h70, d);
`ifdef AXIL_RAM_SLAVE_DECERR_EN
        check("t5_oor_bresp", 64'(resp), 64'd3);
        check("t5_word0", 64'(d), 64'h0);
`else
        check("t5_oor_bresp", 64'(resp), 64'd0);
        check("t5_word0", 64'(d), 64'hCAFEF00D);
`endif
        do_read(32'h44, 8'h71, d);
`ifdef AXIL_RAM_SLAVE_DECERR_EN
        check("t5_oor_read", 64'(d), 64'h0);
`else
        check("t5_oor_read", 64'(d), 64'hA5A5A5A5);
`endif

        // empty strobe writes nothing
        do_write(32'h8, 8'h09, 32'hFFFFFFFF, 4'h0, resp);
        check("t6_strb0_bresp", 64'(resp), 64'd0);
        do_read(32'h8, 8'h72, d);
        check("t6_strb0_data", 64'(d), 64'h0DE22BE44);

        // reset with a B and an R pending
        push_write(32'h8, 8'h33, 32'h0BADF00D, 4'hF);
        bready = 1'b0;
        awaddr = 32'h8; awid = 8'h33; wdata = 32'h0BADF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        push_read(32'h8, 8'h44);
        rready = 1'b0;
        araddr = 32'h8; arid = 8'h44; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("t8_pending", 64'({bvalid, rvalid}), 64'b11);
        arst = 1'b1;
        tick();
        check("t8_reset_outputs", 64'(axil_miso), 64'd0);
        arst = 1'b0;
        exp_b.delete();
        exp_r.delete();
        for (int i = 0; i < WORDS; i++) model_mem[i] = RESET_WORD;
        bready = 1'b1; rready = 1'b1;
        tick();
        check("t8_ready_after", 64'({awready, wready, arready}), 64'h7);
        for (int i = 0; i < WORDS; i++) begin
            do_read(32'(i * 4), 8'(i), d);
            check("t8_word_reset", 64'(d), 64'(RESET_WORD));
        end

        tick();
        check("b_drained", 64'(exp_b.size()), 64'd0);
        check("r_drained", 64'(exp_r.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
